brew_ctrl: RTL and testbench
============================

# brew_ctrl

Parametrised beverage controller FSM for the lab vending/coffee designs. It extends the two-state on/brew controller with a heat-up phase and N selectable drinks. Each drink has its own brew duration. It also adds water-fault handling and a saturating cup counter. It sits between the front-panel inputs (switches/buttons, already debounced and synchronised) and the panel LEDs/heater drive.

## Interface
Parameters:
- N_DRINKS, 4: number of selectable drinks; must be ≥2.
- HEAT_TICKS, 16: cycles spent in HEAT after power-on; must be ≥1.
- BREW_BASE, 32: brew length unit; drink s brews BREW_BASE*(s+1) cycles.
- CNT_W, 8: width of cup counter.
- Derived: SEL_W = clog2(N_DRINKS); TMR_W = clog2(max(HEAT_TICKS, BREW_BASE*N_DRINKS)).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- on  in  1  machine power switch, level.
- start  in  1  brew request, level, sampled only in IDLE.
- sel  in  SEL_W  drink select, sampled with start.
- water_ok  in  1  water tank sensor, 1 = sufficient.
- state_reg  out  3  current state encoding.
- heater  out  1  heater drive.
- ready  out  1  idle and ready for a request.
- led  out  1  brewing indicator.
- done  out  1  one-cycle pulse when a cup completes.
- fault  out  1  water fault latched.
- cups  out  CNT_W  completed cup count, saturating.

## Operation
State encodings: OFF=0, HEAT=1, IDLE=2, BREW=3, DONE=4, FAULT=5. Codes 6 and 7 are illegal and go to OFF on the next edge.

- Global priority: on=0 sends any state to OFF on the next edge. This aborts HEAT or BREW and clears FAULT. cups is not changed and the abort does not count as a cup.
- OFF: on=1 → HEAT and loads timer = HEAT_TICKS-1.
- HEAT: heater=1. The timer decrements each cycle. When the timer reaches 0 → IDLE.
- IDLE: ready=1. On start=1:
  - water_ok=1 → BREW, latch sel into drink_q, load timer = BREW_BASE*(drink_q+1)-1.
  - water_ok=0 → FAULT.
  - No start → remain in IDLE.
- Out-of-range sel (≥N_DRINKS, possible when N_DRINKS is not a power of 2) clamps to N_DRINKS-1.
- BREW: led=1, heater=1. The timer decrements each cycle.
  - water_ok=0 → FAULT. This takes priority over timer expiry, and no cup is counted.
  - Timer reaches 0 → DONE.
- Changes on sel or start during BREW are ignored.
- DONE: done=1 and cups increments on entry to DONE. If cups is already all-ones it holds. Unconditional → IDLE.
- FAULT: fault=1 and all other outputs are 0. The only exit is on=0 → OFF.
- Outputs are a Moore decode of state_reg only. Inactive outputs are 0.

## Timing
- Reset (async assert, synchronous-release domain): state_reg=0 (OFF), timer=0, drink_q=0, cups=0. All outputs are 0.
- Reset asserted mid-brew takes effect immediately, and cups is cleared.
- on rising sampled at edge k: HEAT holds for exactly HEAT_TICKS cycles, then IDLE follows at edge k+HEAT_TICKS.
- start sampled in IDLE at edge k: BREW holds for BREW_BASE*(sel+1) cycles, DONE lasts exactly 1 cycle, then IDLE.
- Total IDLE→IDLE latency = BREW_BASE*(sel+1)+1 cycles.
- If start is held high continuously, a new brew begins on the first IDLE cycle after DONE. There is a minimum of 1 IDLE cycle between brews.
- A water_ok drop in BREW is seen at edge k, and FAULT appears after edge k. Latency is 1 cycle.
- A simultaneous on=0 and any other event resolves to OFF.

## Structure
- Shared package brew_pkg holds:
  - State localparams OFF..FAULT with width 3.
  - A clog2 function.
  - The default parameter values.
- Sub-module brew_timer: loadable TMR_W down-counter with load, value, en and zero outputs. It is instantiated once and shared by HEAT and BREW.
- Top level contains:
  - The next-state logic, as a combinational always block with defaults.
  - The state register.
  - The drink_q and cups registers.
  - The output decode.

## Test plan
- Reset then power-up: with on=1 from cycle 0, heater=1 for 16 cycles, then ready=1 and state_reg=2.
- Brew sel=2 (defaults): start pulse in IDLE gives led=1 for exactly 96 cycles, done=1 for 1 cycle, cups=1, then IDLE.
- Fault handling:
  - water_ok=0 at cycle 40 of a brew gives FAULT next cycle, fault=1 and cups unchanged.
  - on=0 then gives OFF; a later on=1 gives HEAT.
- Abort and reset:
  - on=0 mid-brew gives OFF next edge with cups unchanged.
  - reset low mid-brew gives all outputs 0 and cups=0 immediately, without waiting for clock.
- Saturation and clamping:
  - CNT_W=2: five back-to-back brews with start held high leave cups=3, with exactly 1 IDLE cycle between DONE and BREW.
  - N_DRINKS=3 with sel=3 brews 3*BREW_BASE cycles.

Source files
------------

// File: rtl/brew_pkg.sv
// rtl/brew_pkg.sv - shared state codes, default parameters and sizing helpers for brew_ctrl
package brew_pkg;

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_HEAT  = 3'd1;
  localparam logic [2:0] ST_IDLE  = 3'd2;
  localparam logic [2:0] ST_BREW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam int DEF_N_DRINKS   = 4;
  localparam int DEF_HEAT_TICKS = 16;
  localparam int DEF_BREW_BASE  = 32;
  localparam int DEF_CNT_W      = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/brew_timer.sv
// rtl/brew_timer.sv - loadable down-counter shared by the HEAT and BREW phases
module brew_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [TMR_W-1:0] value_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  // Holds at zero so a stalled phase never wraps into a long count.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/brew_ctrl.sv
// rtl/brew_ctrl.sv - beverage controller: power-up heat, N drinks, water fault, cup counter
module brew_ctrl
  import brew_pkg::*;
#(
  parameter  int N_DRINKS   = DEF_N_DRINKS,
  parameter  int HEAT_TICKS = DEF_HEAT_TICKS,
  parameter  int BREW_BASE  = DEF_BREW_BASE,
  parameter  int CNT_W      = DEF_CNT_W,
  localparam int SEL_W      = clog2(N_DRINKS),
  localparam int TMR_W      = clog2(max2(HEAT_TICKS, BREW_BASE * N_DRINKS))
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             on,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  input  logic             water_ok,
  output logic [2:0]       state_reg,
  output logic             heater,
  output logic             ready,
  output logic             led,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] cups
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_DRINKS - 1);

  logic [2:0]       state_q, state_d;
  logic [SEL_W-1:0] drink_q, drink_d;
  logic [CNT_W-1:0] cups_q, cups_d;
  logic [SEL_W-1:0] sel_clamped;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0] tmr_value;

  function automatic logic [TMR_W-1:0] brew_last(input logic [SEL_W-1:0] s);
    return TMR_W'(BREW_BASE * (int'(s) + 1) - 1);
  endfunction

  assign sel_clamped = (int'(sel) >= N_DRINKS) ? SEL_MAX : sel;

  brew_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .en_i    (tmr_en),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    drink_d   = drink_q;
    cups_d    = cups_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (on) begin
          state_d   = ST_HEAT;
          tmr_load  = 1'b1;
          tmr_value = TMR_W'(HEAT_TICKS - 1);
        end
      end
      ST_HEAT: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (start) begin
          if (water_ok) begin
            state_d   = ST_BREW;
            drink_d   = sel_clamped;
            tmr_load  = 1'b1;
            tmr_value = brew_last(drink_d);
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_BREW: begin
        tmr_en = 1'b1;
        // A dry tank wins over a finishing timer: that cup is not counted.
        if (!water_ok) begin
          state_d = ST_FAULT;
        end else if (tmr_zero) begin
          state_d = ST_DONE;
          if (cups_q != '1) begin
            cups_d = cups_q + 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_OFF;
    endcase
    // Power switch overrides everything, including a cup about to complete.
    if (!on) begin
      state_d  = ST_OFF;
      drink_d  = drink_q;
      cups_d   = cups_q;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OFF;
      drink_q <= '0;
      cups_q  <= '0;
    end else begin
      state_q <= state_d;
      drink_q <= drink_d;
      cups_q  <= cups_d;
    end
  end

  assign state_reg = state_q;
  assign heater    = (state_q == ST_HEAT) || (state_q == ST_BREW);
  assign ready     = (state_q == ST_IDLE);
  assign led       = (state_q == ST_BREW);
  assign done      = (state_q == ST_DONE);
  assign fault     = (state_q == ST_FAULT);
  assign cups      = cups_q;

endmodule

// File: tb/tb_brew_ctrl.sv
// tb/tb_brew_ctrl.sv - randomized self-checking bench for brew_ctrl against a cycle-count model
module tb_brew_ctrl;

  localparam int HEAT  = 16;
  localparam int BASE  = 32;
  localparam int HEAT3 = 3;
  localparam int BASE3 = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic on = 1'b0, start = 1'b0, water_ok = 1'b1;
  logic [1:0] sel = 2'd0;
  logic on3 = 1'b0, start3 = 1'b0, water3 = 1'b1;
  logic [1:0] sel3 = 2'd0;

  logic [2:0] d_state, s_state, t_state;
  logic d_heater, d_ready, d_led, d_done, d_fault;
  logic s_heater, s_ready, s_led, s_done, s_fault;
  logic t_heater, t_ready, t_led, t_done, t_fault;
  logic [7:0] d_cups, t_cups;
  logic [1:0] s_cups;

  int vectors = 0;
  int miscompares = 0;
  int cups_exp = 0, cups_sat_exp = 0, cups3_exp = 0;

  always #5 clock = ~clock;

  brew_ctrl dut (
    .clock(clock), .reset(reset), .on(on), .start(start), .sel(sel), .water_ok(water_ok),
    .state_reg(d_state), .heater(d_heater), .ready(d_ready), .led(d_led),
    .done(d_done), .fault(d_fault), .cups(d_cups));

  brew_ctrl #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .on(on), .start(start), .sel(sel), .water_ok(water_ok),
    .state_reg(s_state), .heater(s_heater), .ready(s_ready), .led(s_led),
    .done(s_done), .fault(s_fault), .cups(s_cups));

  brew_ctrl #(.N_DRINKS(3), .HEAT_TICKS(HEAT3), .BREW_BASE(BASE3)) dut_n3 (
    .clock(clock), .reset(reset), .on(on3), .start(start3), .sel(sel3), .water_ok(water3),
    .state_reg(t_state), .heater(t_heater), .ready(t_ready), .led(t_led),
    .done(t_done), .fault(t_fault), .cups(t_cups));

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic count_cup();
    cups_exp     = (cups_exp < 255) ? cups_exp + 1 : 255;
    cups_sat_exp = (cups_sat_exp < 3) ? cups_sat_exp + 1 : 3;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!d_ready && n < 300) begin
      cyc();
      n++;
    end
    vectors++;
    if (d_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: ready=%0b after %0d cycles, required 1", tag, d_ready, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    vectors++;
    if ({d_state, d_heater, d_ready, d_led, d_done, d_fault} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required 0", {d_state, d_heater, d_ready, d_led, d_done, d_fault});
    end
    vectors++;
    if (d_cups !== 8'd0 || s_cups !== 2'd0 || t_cups !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_cups: got %0d/%0d/%0d, required 0", d_cups, s_cups, t_cups);
    end
    vectors++;
    if ({t_state, t_heater, t_ready, t_led, t_done, t_fault} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_outputs_n3: got %b, required 0", {t_state, t_heater, t_ready, t_led, t_done, t_fault});
    end
    reset = 1'b1;
    on = 1'b1;
  endtask

  task automatic test_power_up();
    int n;
    n = 0;
    cyc();
    vectors++;
    if (d_state !== 3'd1) begin
      miscompares++;
      $display("FAIL heat_entry: state=%0d, required 1", d_state);
    end
    while (d_heater && n < 100) begin
      n++;
      cyc();
    end
    vectors++;
    if (n != HEAT) begin
      miscompares++;
      $display("FAIL heat_length: heater cycles=%0d, required %0d", n, HEAT);
    end
    vectors++;
    if (d_state !== 3'd2 || d_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL heat_to_idle: state=%0d ready=%0b, required 2/1", d_state, d_ready);
    end
  endtask

  task automatic run_brew(input int s, input int drop_at, input string tag);
    int len, n;
    len = BASE * (s + 1);
    n = 0;
    start = 1'b1;
    sel = 2'(s);
    cyc();
    start = 1'b0;
    while (d_led && n < 400) begin
      n++;
      if (n == drop_at) water_ok = 1'b0;
      start = 1'($urandom);
      sel = 2'($urandom);
      cyc();
    end
    start = 1'b0;
    if (drop_at >= 1 && drop_at <= len) begin
      vectors++;
      if (n != drop_at) begin
        miscompares++;
        $display("FAIL %s_fault_time: led cycles=%0d, required %0d", tag, n, drop_at);
      end
      vectors++;
      if (d_fault !== 1'b1 || d_state !== 3'd5 || {d_heater, d_ready, d_led, d_done} !== 4'd0) begin
        miscompares++;
        $display("FAIL %s_fault_out: state=%0d fault=%0b others=%b, required 5/1/0000", tag, d_state, d_fault,
                 {d_heater, d_ready, d_led, d_done});
      end
      vectors++;
      if (d_cups !== 8'(cups_exp) || s_cups !== 2'(cups_sat_exp)) begin
        miscompares++;
        $display("FAIL %s_fault_cups: got %0d/%0d, required %0d/%0d", tag, d_cups, s_cups, cups_exp, cups_sat_exp);
      end
      water_ok = 1'b1;
      on = 1'b0;
      cyc();
      vectors++;
      if (d_state !== 3'd0 || d_fault !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_fault_clear: state=%0d fault=%0b, required 0/0", tag, d_state, d_fault);
      end
      on = 1'b1;
      cyc();
      vectors++;
      if (d_state !== 3'd1 || d_heater !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_reheat: state=%0d heater=%0b, required 1/1", tag, d_state, d_heater);
      end
      wait_ready({tag, "_ready"});
    end else begin
      count_cup();
      vectors++;
      if (n != len) begin
        miscompares++;
        $display("FAIL %s_length: led cycles=%0d, required %0d", tag, n, len);
      end
      vectors++;
      if (d_done !== 1'b1 || d_state !== 3'd4 || s_state !== 3'd4) begin
        miscompares++;
        $display("FAIL %s_done: done=%0b state=%0d/%0d, required 1/4/4", tag, d_done, d_state, s_state);
      end
      vectors++;
      if (d_cups !== 8'(cups_exp) || s_cups !== 2'(cups_sat_exp)) begin
        miscompares++;
        $display("FAIL %s_cups: got %0d/%0d, required %0d/%0d", tag, d_cups, s_cups, cups_exp, cups_sat_exp);
      end
      cyc();
      vectors++;
      if (d_ready !== 1'b1 || d_done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_back_idle: ready=%0b done=%0b, required 1/0", tag, d_ready, d_done);
      end
    end
  endtask

  task automatic abort_brew(input int s, input int k);
    start = 1'b1;
    sel = 2'(s);
    cyc();
    start = 1'b0;
    repeat (k - 1) cyc();
    vectors++;
    if (d_led !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_inflight: led=%0b at cycle %0d, required 1", d_led, k);
    end
    on = 1'b0;
    cyc();
    vectors++;
    if (d_state !== 3'd0 || {d_heater, d_led, d_done} !== 3'd0) begin
      miscompares++;
      $display("FAIL abort_off: state=%0d outs=%b, required 0/000", d_state, {d_heater, d_led, d_done});
    end
    vectors++;
    if (d_cups !== 8'(cups_exp) || s_cups !== 2'(cups_sat_exp)) begin
      miscompares++;
      $display("FAIL abort_cups: got %0d/%0d, required %0d/%0d", d_cups, s_cups, cups_exp, cups_sat_exp);
    end
    on = 1'b1;
    wait_ready("abort_ready");
  endtask

  task automatic test_brew_sel2();
    run_brew(2, 0, "brew_sel2");
  endtask

  task automatic test_fault();
    run_brew($urandom_range(1, 3), 40, "fault40");
  endtask

  task automatic test_idle_fault();
    water_ok = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    water_ok = 1'b1;
    repeat (2) cyc();
    vectors++;
    if (d_state !== 3'd5 || d_fault !== 1'b1 || d_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_fault: state=%0d fault=%0b ready=%0b, required 5/1/0", d_state, d_fault, d_ready);
    end
    on = 1'b0;
    cyc();
    on = 1'b1;
    vectors++;
    if (d_state !== 3'd0) begin
      miscompares++;
      $display("FAIL idle_fault_off: state=%0d, required 0", d_state);
    end
    wait_ready("idle_fault_ready");
  endtask

  task automatic test_abort();
    int s;
    s = $urandom_range(0, 3);
    abort_brew(s, BASE * (s + 1));
  endtask

  task automatic test_random();
    int s, kind;
    for (int i = 0; i < 6; i++) begin
      s = $urandom_range(0, 3);
      kind = $urandom_range(0, 2);
      if (kind == 0) run_brew(s, 0, "rand_brew");
      else if (kind == 1) run_brew(s, $urandom_range(1, BASE * (s + 1)), "rand_drop");
      else abort_brew(s, $urandom_range(1, BASE * (s + 1)));
    end
  endtask

  task automatic test_reset_midbrew();
    run_brew(0, 0, "pre_reset");
    start = 1'b1;
    sel = 2'($urandom);
    cyc();
    start = 1'b0;
    repeat ($urandom_range(2, 20)) cyc();
    #3;
    reset = 1'b0;
    #1;
    cups_exp = 0;
    cups_sat_exp = 0;
    cups3_exp = 0;
    vectors++;
    if ({d_state, d_heater, d_ready, d_led, d_done, d_fault} !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset_outs: got %b, required 0", {d_state, d_heater, d_ready, d_led, d_done, d_fault});
    end
    vectors++;
    if (d_cups !== 8'd0 || s_cups !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset_cups: got %0d/%0d, required 0/0", d_cups, s_cups);
    end
    cyc();
    reset = 1'b1;
    wait_ready("reset_ready");
  endtask

  task automatic test_back_to_back();
    int s, len, n;
    s = $urandom_range(0, 1);
    len = BASE * (s + 1);
    start = 1'b1;
    sel = 2'(s);
    cyc();
    for (int b = 0; b < 5; b++) begin
      n = 0;
      while (d_led && n < 400) begin
        n++;
        cyc();
      end
      count_cup();
      vectors++;
      if (n != len || d_done !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_len%0d: led cycles=%0d done=%0b, required %0d/1", b, n, d_done, len);
      end
      vectors++;
      if (s_cups !== 2'(cups_sat_exp) || d_cups !== 8'(cups_exp)) begin
        miscompares++;
        $display("FAIL b2b_cups%0d: got %0d/%0d, required %0d/%0d", b, s_cups, d_cups, cups_sat_exp, cups_exp);
      end
      if (b == 4) start = 1'b0;
      cyc();
      vectors++;
      if (d_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_gap%0d: ready=%0b, required 1", b, d_ready);
      end
      cyc();
      vectors++;
      if (d_led !== (b < 4)) begin
        miscompares++;
        $display("FAIL b2b_restart%0d: led=%0b, required %0b", b, d_led, (b < 4));
      end
    end
  endtask

  task automatic test_clamp();
    int n, len;
    on3 = 1'b1;
    n = 0;
    cyc();
    while (t_heater && n < 50) begin
      n++;
      cyc();
    end
    vectors++;
    if (n != HEAT3 || t_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL n3_heat: heater cycles=%0d ready=%0b, required %0d/1", n, t_ready, HEAT3);
    end
    for (int s = 3; s >= 0; s--) begin
      len = BASE3 * (((s > 2) ? 2 : s) + 1);
      start3 = 1'b1;
      sel3 = 2'(s);
      cyc();
      start3 = 1'b0;
      n = 0;
      while (t_led && n < 100) begin
        n++;
        cyc();
      end
      cups3_exp++;
      vectors++;
      if (n != len || t_done !== 1'b1) begin
        miscompares++;
        $display("FAIL n3_sel%0d: led cycles=%0d done=%0b, required %0d/1", s, n, t_done, len);
      end
      vectors++;
      if (t_cups !== 8'(cups3_exp)) begin
        miscompares++;
        $display("FAIL n3_cups%0d: got %0d, required %0d", s, t_cups, cups3_exp);
      end
      cyc();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_brew_sel2();
    test_fault();
    test_idle_fault();
    test_abort();
    test_random();
    test_reset_midbrew();
    test_back_to_back();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
